// File: rtl/decode_stage_if.sv
// Handshake bundle for the decode stage: fetch-side word input and decoded-field output.
interface decode_stage_if #(
  parameter int unsigned IW  = 9,
  parameter int unsigned OPW = 5,
  parameter int unsigned RW  = 3,
  parameter int unsigned DW  = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  mach_code;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] opcode;
  logic [RW-1:0]  reg1;
  logic [RW-1:0]  reg2;
  logic [DW-1:0]  immediate;
  logic           is_imm;
  logic           mode;

  modport master (
    output in_valid, mach_code, out_ready,
    input  in_ready, out_valid, opcode, reg1, reg2, immediate, is_imm, mode
  );

  modport slave (
    input  in_valid, mach_code, out_ready,
    output in_ready, out_valid, opcode, reg1, reg2, immediate, is_imm, mode
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with mode tracking, immediate LUT expansion
// and a 2-entry (output + skid) buffer so one word per cycle survives back-pressure.
module decode_stage #(
  parameter int unsigned          IW    = 9,
  parameter int unsigned          OPW   = 5,
  parameter int unsigned          RW    = 3,
  parameter int unsigned          DW    = 8,
  parameter logic [OPW-1:0]       SW_RR = 5'h1F,
  parameter logic [IW-2*RW-1:0]   SW_RI = 3'h7
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          flush,
  decode_stage_if.slave bus
);
  localparam int unsigned RRW = (IW - OPW) / 2;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [RW-1:0]  reg1;
    logic [RW-1:0]  reg2;
    logic [DW-1:0]  imm;
    logic           is_imm;
  } entry_t;

  // Immediate expansion: 0, 1, powers of two, and a saturated top entry.
  function automatic logic [DW-1:0] f_lut(input logic [RW-1:0] idx);
    logic [DW-1:0] v;
    if (idx == '0)            v = '0;
    else if (idx == RW'(1))   v = DW'(1);
    else if (idx == '1)       v = {1'b0, {(DW-1){1'b1}}};
    else                      v = DW'(1) << idx;
    return v;
  endfunction

  logic   r_out_valid, r_skid_valid, r_mode;
  entry_t r_out, r_skid;

  logic   w_out_valid_nx, w_skid_valid_nx, w_mode_nx;
  entry_t w_out_nx, w_skid_nx;
  entry_t w_dec;
  logic   w_sw, w_acc, w_push;

  assign bus.in_ready  = !r_skid_valid && !flush && Reset_n;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_push        = w_acc && !w_sw;

  // Field split depends on the mode in force when the word is accepted.
  always_comb begin
    w_dec = '0;
    w_sw  = 1'b0;
    if (!r_mode) begin
      w_dec.opcode = bus.mach_code[IW-1 -: OPW];
      w_dec.reg1   = RW'(bus.mach_code[2*RRW-1 : RRW]);
      w_dec.reg2   = RW'(bus.mach_code[RRW-1 : 0]);
      w_sw         = (bus.mach_code[IW-1 -: OPW] == SW_RR);
    end else begin
      w_dec.opcode = OPW'(bus.mach_code[IW-1 : 2*RW]);
      w_dec.reg1   = bus.mach_code[2*RW-1 : RW];
      w_dec.reg2   = bus.mach_code[RW-1 : 0];
      w_dec.imm    = f_lut(bus.mach_code[RW-1 : 0]);
      w_dec.is_imm = 1'b1;
      w_sw         = (bus.mach_code[IW-1 : 2*RW] == SW_RI);
    end
  end

  // Buffer occupancy and mode next-state; skid always drains before new words load.
  always_comb begin
    w_out_valid_nx  = r_out_valid;
    w_out_nx        = r_out;
    w_skid_valid_nx = r_skid_valid;
    w_skid_nx       = r_skid;
    w_mode_nx       = r_mode;
    if (w_acc && w_sw) w_mode_nx = !r_mode;
    if (flush) begin
      w_out_valid_nx  = 1'b0;
      w_skid_valid_nx = 1'b0;
    end else if (!r_out_valid || bus.out_ready) begin
      if (r_skid_valid) begin
        w_out_valid_nx  = 1'b1;
        w_out_nx        = r_skid;
        w_skid_valid_nx = 1'b0;
      end else if (w_push) begin
        w_out_valid_nx  = 1'b1;
        w_out_nx        = w_dec;
      end else begin
        w_out_valid_nx  = 1'b0;
      end
    end else if (w_push) begin
      w_skid_valid_nx = 1'b1;
      w_skid_nx       = w_dec;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_mode       <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid_nx;
      r_out        <= w_out_nx;
      r_skid_valid <= w_skid_valid_nx;
      r_skid       <= w_skid_nx;
      r_mode       <= w_mode_nx;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.opcode    = r_out.opcode;
  assign bus.reg1      = r_out.reg1;
  assign bus.reg2      = r_out.reg2;
  assign bus.immediate = r_out.imm;
  assign bus.is_imm    = r_out.is_imm;
  assign bus.mode      = r_mode;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.IW(9), .OPW(5), .RW(3), .DW(8)) bus ();

  decode_stage dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .flush   (flush),
    .bus     (bus)
  );

  typedef struct {
    int op;
    int r1;
    int r2;
    int imm;
    int isi;
  } ent_t;

  ent_t mq[$];
  int   m_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lut(input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    if (idx == 7) return 127;
    return (1 << idx) & 255;
  endfunction

  // Reference model: outputs checked mid-cycle, then the coming edge is applied.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_mode = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mode", 32'(bus.mode), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    end else begin
      bit   rdy;
      int   c;
      int   op;
      int   r2;
      ent_t e;
      rdy = (mq.size() < 2) && !flush;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("mode", 32'(bus.mode), 32'(m_mode));
      if (mq.size() != 0) begin
        chk("opcode", 32'(bus.opcode), 32'(mq[0].op));
        chk("reg1", 32'(bus.reg1), 32'(mq[0].r1));
        chk("reg2", 32'(bus.reg2), 32'(mq[0].r2));
        chk("immediate", 32'(bus.immediate), 32'(mq[0].imm));
        chk("is_imm", 32'(bus.is_imm), 32'(mq[0].isi));
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
        if (bus.in_valid && rdy) begin
          c = int'(bus.mach_code);
          if (m_mode == 0) begin
            op = c >> 4;
            if (op == 31) m_mode = 1;
            else begin
              e = '{op, (c >> 2) & 3, c & 3, 0, 0};
              mq.push_back(e);
            end
          end else begin
            op = c >> 6;
            if (op == 7) m_mode = 0;
            else begin
              r2 = c & 7;
              e = '{op, (c >> 3) & 7, r2, lut(r2), 1};
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] code, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.mach_code = code;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  int imm_exp[8] = '{0, 1, 4, 8, 16, 32, 64, 127};

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    step();
    step();
    chk("t0_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t0_opcode", 32'(bus.opcode), 32'd0);
    chk("t0_immediate", 32'(bus.immediate), 32'd0);
    chk("t0_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t0_in_ready_rel", 32'(bus.in_ready), 32'd1);

    // Reg-reg decode
    drive(1'b1, 9'b00101_10_11, 1'b1, 1'b0);
    step();
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_opcode", 32'(bus.opcode), 32'd5);
    chk("t1_reg1", 32'(bus.reg1), 32'd2);
    chk("t1_reg2", 32'(bus.reg2), 32'd3);
    chk("t1_imm", 32'(bus.immediate), 32'd0);
    chk("t1_is_imm", 32'(bus.is_imm), 32'd0);

    // Switch to reg-imm, then decode
    drive(1'b1, 9'h1F0, 1'b1, 1'b0);
    step();
    chk("t2_mode", 32'(bus.mode), 32'd1);
    chk("t2_swallowed", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 9'b010_011_101, 1'b1, 1'b0);
    step();
    chk("t2_opcode", 32'(bus.opcode), 32'd2);
    chk("t2_reg1", 32'(bus.reg1), 32'd3);
    chk("t2_reg2", 32'(bus.reg2), 32'd5);
    chk("t2_imm", 32'(bus.immediate), 32'd32);
    chk("t2_is_imm", 32'(bus.is_imm), 32'd1);

    // LUT sweep, then switch back
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 9'(9'b001_000_000 | k), 1'b1, 1'b0);
      step();
      chk($sformatf("t3_imm%0d", k), 32'(bus.immediate), 32'(imm_exp[k]));
    end
    drive(1'b1, 9'b111_000_000, 1'b1, 1'b0);
    step();
    chk("t3_mode", 32'(bus.mode), 32'd0);
    chk("t3_swallowed", 32'(bus.out_valid), 32'd0);

    // Back-pressure with skid
    drive(1'b1, 9'b00001_00_01, 1'b0, 1'b0);
    step();
    drive(1'b1, 9'b00010_00_10, 1'b0, 1'b0);
    step();
    chk("t4_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("t4_hold_a", 32'(bus.opcode), 32'd1);
    drive(1'b1, 9'b00011_00_11, 1'b0, 1'b0);
    step();
    chk("t4_stable_a", 32'(bus.opcode), 32'd1);
    chk("t4_stable_r2", 32'(bus.reg2), 32'd1);
    drive(1'b1, 9'b00011_00_11, 1'b1, 1'b0);
    step();
    chk("t4_out_b", 32'(bus.opcode), 32'd2);
    step();
    chk("t4_out_c", 32'(bus.opcode), 32'd3);
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    step();
    chk("t4_empty", 32'(bus.out_valid), 32'd0);

    // Flush with both slots full and a pending switch word
    drive(1'b1, 9'b00100_00_00, 1'b0, 1'b0);
    step();
    drive(1'b1, 9'b00101_00_00, 1'b0, 1'b0);
    step();
    drive(1'b1, 9'h1F0, 1'b0, 1'b1);
    #1;
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_mode", 32'(bus.mode), 32'd0);
    step();

    // Async reset mid-stall in reg-imm mode
    drive(1'b1, 9'h1F0, 1'b0, 1'b0);
    step();
    drive(1'b1, 9'b001_001_010, 1'b0, 1'b0);
    step();
    drive(1'b1, 9'b001_010_011, 1'b0, 1'b0);
    step();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    chk("t6_mode_pre", 32'(bus.mode), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_mode", 32'(bus.mode), 32'd0);
    step();
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 9'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 49) == 0));
      step();
    end
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
